// File: rtl/btn_arb_pkg.sv
// Shared types for btn_event_arbiter: FSM state encoding and cooldown counter sizing.
package btn_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OFFER    = 2'd1,
      COOLDOWN = 2'd2
   } arb_state_e;

   // Bits needed to hold 0..cycles, never less than one.
   function automatic int unsigned cd_cnt_width(input int unsigned cycles);
      if (cycles == 0) return 1;
      return $clog2(cycles + 1);
   endfunction

endpackage

// File: rtl/btn_event_arbiter_if.sv
// Command handshake between the button arbiter and downstream mode/control logic.
interface btn_event_arbiter_if #(
   parameter int unsigned ID_W = 2
);
   logic            cmd_valid;
   logic [ID_W-1:0] cmd_id;
   logic            cmd_ready;

   modport master (output cmd_valid, output cmd_id, input cmd_ready);
   modport slave  (input cmd_valid, input cmd_id, output cmd_ready);
endinterface

// File: rtl/rr_pick.sv
// Combinational grant picker: first set bit above ptr, wrapping; with
// BTN_ARB_FIXED_PRIO_EN defined it is a lowest-index priority encoder.
module rr_pick #(
   parameter int unsigned N_BTN = 4,
   parameter int unsigned ID_W  = 2
) (
   input  logic [N_BTN-1:0] pending,
`ifndef BTN_ARB_FIXED_PRIO_EN
   input  logic [ID_W-1:0]  ptr,
`endif
   output logic             any,
   output logic [ID_W-1:0]  idx
);

   assign any = |pending;

`ifdef BTN_ARB_FIXED_PRIO_EN
   always_comb begin
      idx = '0;
      for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
         if (pending[i]) idx = ID_W'(i);
      end
   end
`else
   logic            hit_hi;
   logic [ID_W-1:0] idx_hi;
   logic [ID_W-1:0] idx_lo;

   // Lowest set bit strictly above ptr wins; otherwise wrap to lowest set bit at or below ptr.
   always_comb begin
      hit_hi = 1'b0;
      idx_hi = '0;
      idx_lo = '0;
      for (int i = int'(N_BTN) - 1; i >= 0; i--) begin
         if (pending[i]) begin
            if (ID_W'(i) > ptr) begin
               hit_hi = 1'b1;
               idx_hi = ID_W'(i);
            end else begin
               idx_lo = ID_W'(i);
            end
         end
      end
      idx = hit_hi ? idx_hi : idx_lo;
   end
`endif

endmodule

// File: rtl/btn_event_arbiter.sv
// Latches button event pulses as pending requests and offers them one at a time
// over a valid/ready command port. Build option: BTN_ARB_FIXED_PRIO_EN (fixed priority).
module btn_event_arbiter
   import btn_arb_pkg::*;
#(
   parameter int unsigned N_BTN           = 4,
   parameter int unsigned COOLDOWN_CYCLES = 1000
) (
   input  logic                 sys_clk,
   input  logic                 rst_n,
   input  logic [N_BTN-1:0]     btn_pulse,
   btn_event_arbiter_if.master  cmd,
   output logic [N_BTN-1:0]     overrun,
   input  logic                 overrun_clr,
   output logic                 busy
);

   localparam int unsigned ID_W = $clog2(N_BTN);
   localparam int unsigned CD_W = cd_cnt_width(COOLDOWN_CYCLES);
   localparam logic [CD_W-1:0] CD_LOAD = CD_W'(COOLDOWN_CYCLES - 1);

   arb_state_e       state_q, state_d;
   logic [N_BTN-1:0] pending_q, pending_d;
   logic [N_BTN-1:0] overrun_d;
   logic [N_BTN-1:0] clr_vec;
   logic [N_BTN-1:0] ovr_evt;
   logic             valid_q, valid_d;
   logic [ID_W-1:0]  id_q, id_d;
   logic [CD_W-1:0]  cd_q, cd_d;
   logic             busy_d;
   logic             accept;
   logic             pick_any;
   logic [ID_W-1:0]  pick_idx;
`ifndef BTN_ARB_FIXED_PRIO_EN
   logic [ID_W-1:0]  ptr_q, ptr_d;
`endif

   assign accept        = valid_q & cmd.cmd_ready;
   assign cmd.cmd_valid = valid_q;
   assign cmd.cmd_id    = id_q;

   rr_pick #(
      .N_BTN (N_BTN),
      .ID_W  (ID_W)
   ) u_pick (
      .pending (pending_q),
`ifndef BTN_ARB_FIXED_PRIO_EN
      .ptr     (ptr_q),
`endif
      .any     (pick_any),
      .idx     (pick_idx)
   );

   // Acceptance clears the granted bit; a same-cycle pulse on that channel re-arms it without overrun.
   always_comb begin
      clr_vec = '0;
      if (accept) clr_vec[id_q] = 1'b1;
      pending_d = (pending_q & ~clr_vec) | btn_pulse;
      ovr_evt   = btn_pulse & pending_q & ~clr_vec;
      overrun_d = (overrun_clr ? '0 : overrun) | ovr_evt;
   end

   // Next-state and registered-output logic.
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      id_d    = id_q;
      cd_d    = cd_q;
`ifndef BTN_ARB_FIXED_PRIO_EN
      ptr_d   = ptr_q;
`endif
      unique case (state_q)
         IDLE: begin
            if (pick_any) begin
               state_d = OFFER;
               valid_d = 1'b1;
               id_d    = pick_idx;
`ifndef BTN_ARB_FIXED_PRIO_EN
               ptr_d   = pick_idx;
`endif
            end
         end
         OFFER: begin
            if (accept) begin
               valid_d = 1'b0;
               if (COOLDOWN_CYCLES == 0) begin
                  state_d = IDLE;
               end else begin
                  state_d = COOLDOWN;
                  cd_d    = CD_LOAD;
               end
            end
         end
         COOLDOWN: begin
            if (cd_q == '0) state_d = IDLE;
            else            cd_d    = cd_q - CD_W'(1);
         end
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge sys_clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         pending_q <= '0;
         overrun   <= '0;
         valid_q   <= 1'b0;
         id_q      <= '0;
         cd_q      <= '0;
         busy      <= 1'b0;
`ifndef BTN_ARB_FIXED_PRIO_EN
         ptr_q     <= ID_W'(N_BTN - 1);
`endif
      end else begin
         state_q   <= state_d;
         pending_q <= pending_d;
         overrun   <= overrun_d;
         valid_q   <= valid_d;
         id_q      <= id_d;
         cd_q      <= cd_d;
         busy      <= busy_d;
`ifndef BTN_ARB_FIXED_PRIO_EN
         ptr_q     <= ptr_d;
`endif
      end
   end

endmodule

// File: doc/btn_event_arbiter.md
Name: btn_event_arbiter

Overview:
Collects one-cycle event pulses from N_BTN debounced button channels and latches each as a pending request. Grants pending requests round-robin and presents them one at a time to downstream mode/control logic over a valid/ready command handshake. An optional inter-command cooldown and a sticky per-channel overrun flag complete the block. It sits between the bank of signal debouncers and the MITM mode controller.

Parameters:
N_BTN, 4, number of button event channels (2..16)
COOLDOWN_CYCLES, 1000, idle sys_clk cycles enforced after each accepted command (0 = none)
ID_W, $clog2(N_BTN), width of cmd_id (derived localparam, not overridable)

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
btn_pulse  in  N_BTN  active-high one-cycle event pulses, synchronous to sys_clk
cmd_valid  out  1  command offered
cmd_id  out  ID_W  index of granted channel; stable while cmd_valid=1
cmd_ready  in  1  downstream accepts when cmd_valid & cmd_ready
overrun  out  N_BTN  sticky: pulse arrived while that channel already pending
overrun_clr  in  1  one-cycle clear of all overrun bits
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync-released): state=IDLE, pending=0, cmd_valid=0, cmd_id=0, overrun=0, busy=0, rr_ptr=N_BTN-1 (channel 0 wins first), cooldown counter=0.
- Pending: btn_pulse[i]=1 sets pending[i] at the next edge. If pending[i] is already 1 and is not being cleared that cycle, the pulse is dropped and overrun[i] is set.
- Set/clear collision: if pending[i] is cleared by acceptance and btn_pulse[i]=1 in the same cycle, pending[i] stays 1 and no overrun is flagged.
- overrun_clr clears all bits. A same-cycle new overrun event wins, leaving that bit set.
- FSM states: IDLE, OFFER, COOLDOWN.
- IDLE: if pending!=0, pick the first set bit searching from rr_ptr+1 upward, wrapping at N_BTN. Register cmd_id=winner, cmd_valid=1, rr_ptr=winner, then go to OFFER.
- OFFER: cmd_valid=1, cmd_id held. The pending bit of the granted channel remains set until acceptance.
  - On cmd_valid & cmd_ready: clear pending[cmd_id] and drop cmd_valid the next cycle.
  - Then go to COOLDOWN, loading the counter with COOLDOWN_CYCLES-1, or go to IDLE if COOLDOWN_CYCLES==0.
  - Without acceptance, hold indefinitely; there is no timeout and no re-arbitration.
- COOLDOWN: decrement the counter each cycle and go to IDLE when it reaches 0. Pulses still latch into pending.
- Latency: pulse sampled at edge t sets pending at t. With an idle arbiter, cmd_valid is high after edge t+1. Back-to-back commands are spaced by at least 1 + COOLDOWN_CYCLES cycles (idle cycle in IDLE + cooldown).
- busy = (state != IDLE), registered.
- cmd_valid never deasserts without acceptance. cmd_id never changes while cmd_valid=1.
- The cooldown counter width is $clog2(COOLDOWN_CYCLES+1), minimum 1 bit.

Optional Feature:
Macro BTN_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, lowest index wins; rr_ptr is not implemented.
- Undefined (default): round-robin as above.
- All ports and handshake rules are identical in both builds.

Decomposition:
- Package btn_arb_pkg holds the state enum (IDLE, OFFER, COOLDOWN) and a function computing the cooldown counter width.
- One sub-module, rr_pick, is natural: combinational input pending[N_BTN] and ptr[ID_W], outputs any and idx[ID_W]. Under BTN_ARB_FIXED_PRIO_EN it degenerates to a priority encoder.
- The top level holds the pending/overrun registers, FSM and cooldown counter.

Test Plan:
- Reset mid-OFFER (N_BTN=4, cmd_valid=1, cmd_id=2) with rst_n low for 1 cycle -> all outputs 0 immediately; after release, the next pulse on ch1 yields cmd_id=1 two cycles later.
- Single event: COOLDOWN_CYCLES=3, pulse ch2 at cycle 10 with cmd_ready tied 1 -> cmd_valid high for exactly cycle 12 with cmd_id=2; busy high cycles 12-15; idle by cycle 16.
- Round-robin fairness: pulses on ch0, ch1, ch3 in the same cycle, cmd_ready=1, COOLDOWN_CYCLES=0 -> grant order 0, 1, 3. A repeat of all four after reset grants 0, 1, 2, 3, then wraps to 0. With BTN_ARB_FIXED_PRIO_EN, new ch0 pulses always preempt ch3.
- Backpressure: cmd_ready=0 for 50 cycles after ch1 is offered -> cmd_valid and cmd_id=1 stable throughout; a ch3 pulse meanwhile stays pending and is granted after ch1 is accepted plus cooldown.
- Overrun: ch0 pulsed twice while pending (cmd_ready=0) -> overrun=4'b0001. overrun_clr in the same cycle as a third ch0 pulse -> bit stays 1. A later lone overrun_clr -> 0.
- Collision: ch2 accepted in the same cycle as a new ch2 pulse -> no overrun; ch2 is offered again after cooldown.
